// File: rtl/vol_sqrt.sv
// Variance (E[x^2] - E[x]^2, floored at zero) and floor(sqrt(variance)) via restoring square root.
// Optional macro VOL_SQRT_CLAMP_FLAG_EN adds the clamp_flag output reporting that the zero-floor fired.
module vol_sqrt #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   mean_in,
  input  logic [W-1:0]   sec_mom_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   var_out,
  output logic [W/2-1:0] std_out,
  output logic           out_valid,
  input  logic           out_ready
`ifdef VOL_SQRT_CLAMP_FLAG_EN
  ,
  output logic           clamp_flag
`endif
);

  localparam int H  = W / 2;
  localparam int RW = H + 2;
  localparam int CW = $clog2(H) + 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  typedef enum logic [1:0] {IDLE, CALC, SQRT, DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_mean;
  logic [W-1:0]   r_sec;
  logic [W-1:0]   r_var;
  logic [W-1:0]   r_rad;
  logic [RW-1:0]  r_rem;
  logic [H-1:0]   r_root;
  logic [H-1:0]   r_std;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;
`ifdef VOL_SQRT_CLAMP_FLAG_EN
  logic           r_clamp;
`endif

  logic [2*W-1:0] w_mean_sq;
  logic           w_clamp;
  logic [W-1:0]   w_var;
  logic [RW-1:0]  w_rem_sh;
  logic [RW-1:0]  w_trial;
  logic           w_ge;
  logic [RW-1:0]  w_rem_next;
  logic [H-1:0]   w_root_next;

  // Full-width square; the floor compares against the zero-extended second moment.
  assign w_mean_sq = {{W{1'b0}}, r_mean} * {{W{1'b0}}, r_mean};
  assign w_clamp   = w_mean_sq > {{W{1'b0}}, r_sec};
  assign w_var     = w_clamp ? '0 : (r_sec - w_mean_sq[W-1:0]);

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  assign w_rem_sh    = (r_rem << 2) | {{H{1'b0}}, r_rad[W-1:W-2]};
  assign w_trial     = {r_root, 2'b01};
  assign w_ge        = w_rem_sh >= w_trial;
  assign w_rem_next  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_next = (r_root << 1) | {{(H-1){1'b0}}, w_ge};

  assign in_ready  = (r_state == IDLE) && !rst;
  assign var_out   = r_var;
  assign std_out   = r_std;
  assign out_valid = r_out_valid;
`ifdef VOL_SQRT_CLAMP_FLAG_EN
  assign clamp_flag = r_clamp;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = CALC;
      CALC:    w_state_next = SQRT;
      SQRT:    if (r_cnt == LAST) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mean      <= '0;
      r_sec       <= '0;
      r_var       <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_std       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
`ifdef VOL_SQRT_CLAMP_FLAG_EN
      r_clamp     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mean <= mean_in;
            r_sec  <= sec_mom_in;
          end
        end
        CALC: begin
          r_var  <= w_var;
          r_rad  <= w_var;
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= '0;
`ifdef VOL_SQRT_CLAMP_FLAG_EN
          r_clamp <= w_clamp;
`endif
        end
        SQRT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_std       <= w_root_next;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vol_sqrt.sv
// Scoreboard bench for vol_sqrt: accepted inputs push model results, a negedge monitor checks outputs.
module tb_vol_sqrt;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   mean_in = '0;
  logic [W-1:0]   sec_mom_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   var_out;
  logic [W/2-1:0] std_out;
  logic           out_valid;
  logic           out_ready = 1'b1;
`ifdef VOL_SQRT_CLAMP_FLAG_EN
  logic           clamp_flag;
`endif

  vol_sqrt #(.W(W)) dut (
    .clk(clk), .rst(rst), .mean_in(mean_in), .sec_mom_in(sec_mom_in),
    .in_valid(in_valid), .in_ready(in_ready), .var_out(var_out), .std_out(std_out),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef VOL_SQRT_CLAMP_FLAG_EN
    , .clamp_flag(clamp_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int s;
    int c;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  int   rise_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer variance and the largest r with r*r <= variance.
  function automatic exp_t model(input int m, input int s, input int acc);
    exp_t e;
    int r;
    e.c = (m * m > s) ? 1 : 0;
    e.v = e.c ? 0 : s - m * m;
    r = 0;
    while ((r + 1) * (r + 1) <= e.v) r++;
    e.s = r;
    e.acc = acc;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Monitor: records accepted inputs and checks every cycle an output is presented.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back(model(int'(mean_in), int'(sec_mom_in), cyc + 1));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got var=%0d std=%0d expected none", var_out, std_out);
        end else begin
          if (!prev_ov) begin
            rise_q.push_back(cyc);
            check("latency", 32'(cyc - sb_q[0].acc), 32'd9);
          end
          check("var_out", 32'(var_out), 32'(sb_q[0].v));
          check("std_out", 32'(std_out), 32'(sb_q[0].s));
`ifdef VOL_SQRT_CLAMP_FLAG_EN
          check("clamp_flag", 32'(clamp_flag), 32'(sb_q[0].c));
`endif
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int m, input int s);
    bit done;
    done = 1'b0;
    mean_in  = W'(m);
    sec_mom_in = W'(s);
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  bit rand_phase;

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_var_out", 32'(var_out), 32'd0);
    check("rst_std_out", 32'(std_out), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic, clamp and boundary vectors with the consumer always ready.
    send(10, 136);    drain();
    send(12, 140);    drain();
    send(10, 136);    drain();
    send(0, 65535);   drain();
    send(0, 0);       drain();
    send(255, 65025); drain();
    send(0, 99);      drain();

    // Backpressure: result held while new data waits upstream.
    out_ready = 1'b0;
    send(3, 50);
    mean_in = 16'd7;
    sec_mom_in = 16'd100;
    in_valid = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("bp_out_valid_seen", 32'(seen), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Back-to-back throughput.
    rise_q.delete();
    send(20, 1000);
    send(100, 10500);
    send(50, 2600);
    drain();
    check("b2b_count", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap1", 32'(rise_q[1] - rise_q[0]), 32'd11);
      check("b2b_gap2", 32'(rise_q[2] - rise_q[1]), 32'd11);
    end

    // Randomized vectors under random backpressure.
    rand_phase = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int m, s;
          m = $urandom_range(0, 255);
          case ($urandom_range(0, 2))
            0: s = $urandom_range(0, 65535);
            1: s = m * m + $urandom_range(0, 600);
            default: s = m * m - $urandom_range(0, 300);
          endcase
          if (s > 65535) s = 65535;
          if (s < 0) s = 0;
          send(m, s);
        end
        drain();
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset during the fifth square-root iteration.
    send(10, 136);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_var_out", 32'(var_out), 32'd0);
    check("mid_rst_std_out", 32'(std_out), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(10, 136);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
